time_cmd_parser: RTL
====================

// Module: time_cmd_parser
// PURPOSE
//  Receives an ASCII byte stream (e.g. from a UART receiver) and decodes time-set commands
//  "Thh:mm:ss" followed by CR or LF.
//  On a valid frame it emits a packed 24-bit time word and a one-cycle load strobe for the watch
//  datapath. This is the write side of the packed time bus, which the watch drives to the display.
//  Time word packing: [23:19] hour, [18:13] min, [12:7] sec, [6:0] msec (centiseconds).
// PARAMETERS
//  TIMEOUT_CYC  1_000_000  max clk cycles between bytes of one frame (10 ms @100 MHz)
//  INIT_HOUR    12         reset value of o_time hour field
// PORTS
//  clk         in   1   system clock
//  reset       in   1   synchronous, active-high reset
//  i_rx_data   in   8   received ASCII byte
//  i_rx_valid  in   1   1-cycle strobe: i_rx_data is valid this cycle
//  o_time      out  24  last successfully decoded time, packed as above
//  o_load      out  1   1-cycle pulse: o_time was just updated
//  o_err       out  1   1-cycle pulse: frame rejected (syntax, range or timeout)
// BEHAVIOUR
//  - One clock and one synchronous active-high reset. All outputs are registered.
//  - Reset values:
//    - o_time = {INIT_HOUR, 6'd0, 6'd0, 7'd0}
//    - o_load = 0, o_err = 0
//    - FSM = IDLE, timeout counter = 0
//  - FSM states: IDLE, H1, H0, C1, M1, M0, C2, S1, S0, TERM
//    (plus DOT, F1, F0 when the optional feature is enabled).
//  - The FSM advances only on cycles where i_rx_valid=1. One byte is consumed per valid cycle.
//  - IDLE: 'T' -> H1. Any other byte is silently ignored (no o_err).
//  - Hx/Mx/Sx states: accept '0'..'9' only.
//    - Tens digit is stored; field = tens*10 + ones (7-bit arithmetic).
//    - A non-digit byte -> o_err and go to IDLE.
//  - C1/C2: accept ':' only. Any other byte -> o_err and go to IDLE.
//  - After S0 -> TERM.
//    - TERM: 0x0D or 0x0A -> range check. Any other byte -> o_err and go to IDLE.
//  - Range check: hour<=23, min<=59, sec<=59.
//    - Pass: o_time <= new word with msec=0, o_load=1, go to IDLE.
//    - Fail: o_err=1, o_time unchanged, go to IDLE.
//    - o_load/o_err assert exactly 1 cycle after the terminator byte is accepted.
//  - 'T' received in any non-IDLE state: restart the frame at H1. This is not an error.
//  - Timeout:
//    - Counter clears on every valid byte and counts while the FSM is outside IDLE.
//    - Reaching TIMEOUT_CYC-1 -> o_err pulse, go to IDLE.
//    - If a byte arrives in that same cycle, the byte wins and the timeout is discarded.
//  - o_load and o_err are never asserted in the same cycle. o_time changes only with o_load.
//  - Reset mid-frame: the frame is discarded, no pulse, o_time returns to its reset value.
// CONFIGURATION
//  TIME_CMD_PARSER_MSEC_EN
//  - Defined:
//    - In TERM, '.' -> DOT state, then F1, F0 take two digits cc. After F0 the FSM returns to TERM.
//    - Range check adds cc<=99, always true.
//    - o_time[6:0] = cc. Frames without ".cc" load msec=0.
//  - Undefined:
//    - '.' in TERM -> o_err.
//    - States DOT, F1, F0 do not exist and msec is always 0.
// TESTING
//  - Bytes "T13:45:07\r" -> o_load 1 cycle after '\r'; o_time = {5'd13, 6'd45, 6'd7, 7'd0}.
//  - "T24:00:00\n" -> o_err pulse, no o_load; o_time keeps its prior value.
//  - "T12:3x" -> o_err on 'x'. Then "T01:02:03\n" -> o_time = {1, 2, 3, 0}.
//  - "T12:3T09:10:11\r" -> restart on the second 'T', no o_err; loads {9, 10, 11, 0}.
//  - "T12:" then no bytes for TIMEOUT_CYC cycles -> one o_err pulse, FSM returns to IDLE.
//  - MSEC_EN defined: "T23:59:59.99\r" -> o_time = {23, 59, 59, 99}.
//    MSEC_EN undefined: the same bytes -> o_err on '.'.
//  - Assert reset while in state M0 -> all outputs return to reset values.
//    Then "T00:00:00\n" -> loads all zeros.

Source files
------------

// File: rtl/time_cmd_parser.sv
// Time-set command parser: decodes "Thh:mm:ss" + CR/LF from an ASCII byte stream into a packed time word.
// Optional ".cc" centisecond suffix is compiled in when TIME_CMD_PARSER_MSEC_EN is defined.
module time_cmd_parser #(
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned INIT_HOUR   = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [23:0] o_time,
  output logic        o_load,
  output logic        o_err
);

  localparam int unsigned     CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [23:0]     TIME_RST = {5'(INIT_HOUR), 19'd0};

  typedef enum logic [3:0] {
    IDLE, H1, H0, C1, M1, M0, C2, S1, S0, TERM
`ifdef TIME_CMD_PARSER_MSEC_EN
    , DOT, F1, F0
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       tens_q, tens_d;
  logic [6:0]       hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic [23:0]      time_q, time_d;
  logic             load_q, load_d, err_q, err_d;
  logic             bad;
  logic [6:0]       msec;
`ifdef TIME_CMD_PARSER_MSEC_EN
  logic [6:0]       cc_q, cc_d;
`endif

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  function automatic logic is_term(input logic [7:0] b);
    return (b == 8'h0D) || (b == 8'h0A);
  endfunction

  function automatic logic [6:0] field_val(input logic [3:0] tens, input logic [3:0] ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

`ifdef TIME_CMD_PARSER_MSEC_EN
  assign msec = cc_q;
`else
  assign msec = 7'd0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tens_d  = tens_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    time_d  = time_q;
    load_d  = 1'b0;
    err_d   = 1'b0;
    bad     = 1'b0;
`ifdef TIME_CMD_PARSER_MSEC_EN
    cc_d    = cc_q;
`endif
    if (i_rx_valid) begin
      cnt_d = '0;
      // A 'T' anywhere starts a fresh frame, abandoning any partial one silently
      if (i_rx_data == 8'h54) begin
        state_d = H1;
      end else begin
        case (state_q)
          IDLE: ;
          H1, M1, S1: begin
            if (is_digit(i_rx_data)) begin
              tens_d  = i_rx_data[3:0];
              state_d = (state_q == H1) ? H0 : (state_q == M1) ? M0 : S0;
            end else bad = 1'b1;
          end
          H0: begin
            if (is_digit(i_rx_data)) begin
              hour_d  = field_val(tens_q, i_rx_data[3:0]);
              state_d = C1;
            end else bad = 1'b1;
          end
          M0: begin
            if (is_digit(i_rx_data)) begin
              min_d   = field_val(tens_q, i_rx_data[3:0]);
              state_d = C2;
            end else bad = 1'b1;
          end
          S0: begin
            if (is_digit(i_rx_data)) begin
              sec_d   = field_val(tens_q, i_rx_data[3:0]);
              state_d = TERM;
`ifdef TIME_CMD_PARSER_MSEC_EN
              cc_d    = 7'd0;
`endif
            end else bad = 1'b1;
          end
          C1, C2: begin
            if (i_rx_data == 8'h3A) state_d = (state_q == C1) ? M1 : S1;
            else bad = 1'b1;
          end
`ifdef TIME_CMD_PARSER_MSEC_EN
          DOT: begin
            if (is_digit(i_rx_data)) begin
              tens_d  = i_rx_data[3:0];
              state_d = F1;
            end else bad = 1'b1;
          end
          F1: begin
            if (is_digit(i_rx_data)) begin
              cc_d    = field_val(tens_q, i_rx_data[3:0]);
              state_d = F0;
            end else bad = 1'b1;
          end
          // F0 has both fraction digits and accepts exactly what TERM accepts
          TERM, F0: begin
`else
          TERM: begin
`endif
            if (is_term(i_rx_data)) begin
              state_d = IDLE;
              if ((hour_q <= 7'd23) && (min_q <= 7'd59) && (sec_q <= 7'd59)) begin
                time_d = {hour_q[4:0], min_q[5:0], sec_q[5:0], msec};
                load_d = 1'b1;
              end else bad = 1'b1;
`ifdef TIME_CMD_PARSER_MSEC_EN
            end else if (i_rx_data == 8'h2E) begin
              state_d = DOT;
`endif
            end else bad = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
    end else if (state_q != IDLE) begin
      // An arriving byte always beats the timeout because it is handled above
      if (cnt_q == CNT_LAST) begin
        bad   = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
    if (bad) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      time_q  <= TIME_RST;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      time_q  <= time_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    tens_q <= tens_d;
    hour_q <= hour_d;
    min_q  <= min_d;
    sec_q  <= sec_d;
`ifdef TIME_CMD_PARSER_MSEC_EN
    cc_q   <= cc_d;
`endif
  end

  assign o_time = time_q;
  assign o_load = load_q;
  assign o_err  = err_q;

endmodule
